// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: ALU op codes,
// sequencer state encoding and the multiply/divide step mode.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_ASR = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } seq_state_t;

    typedef enum logic {
        MD_MUL,
        MD_DIV
    } md_mode_t;

    // Ops the ALU completes in a single combinational pass.
    function automatic logic is_exec_op(input logic [ALU_OP_W-1:0] op);
        return (op <= ALU_NOT) || ((op >= ALU_SHL) && (op <= ALU_ROR));
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-drive signals of the sequencer; the sequencer
// uses the slave modport, the requester/ALU side the master modport.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic                req_valid;
    logic                req_ready;
    logic [ALU_OP_W-1:0] req_op;
    logic [WIDTH-1:0]    req_a;
    logic [WIDTH-1:0]    req_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [WIDTH-1:0]    alu_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_hi;
    logic [WIDTH-1:0]    rsp_lo;
    logic                rsp_err;
    logic                busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );

endinterface

// File: rtl/alu_seq_md_step.sv
// One shift-add multiply or restoring-divide step: ALU operands for this
// step and the next {acc,mq} / {R,Q} given the ALU's combinational result.
module alu_seq_md_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] step_a,
    output logic [WIDTH-1:0] step_b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] s;
    logic           carry;
    logic           take;

    always_comb begin
        s       = {hi, lo[WIDTH-1]};
        carry   = (alu_result < hi);
        take    = s[WIDTH] | (s[WIDTH-1:0] >= opnd);
        step_a  = '0;
        step_b  = '0;
        hi_next = hi;
        lo_next = lo;
        if (mode == MD_MUL) begin
            step_a  = hi;
            step_b  = lo[0] ? opnd : '0;
            // {carry, sum, mq} shifted right by one
            hi_next = {carry, alu_result[WIDTH-1:1]};
            lo_next = {alu_result[0], lo[WIDTH-1:1]};
        end else begin
            step_a  = s[WIDTH-1:0];
            step_b  = opnd;
            // ALU difference is exact mod 2^WIDTH even when the shifted-out bit was set
            hi_next = take ? alu_result : s[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], take};
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 8-bit ALU: single-cycle ops pass through,
// MUL/DIV are sequenced as 8 ADD/SUB steps, results returned via rsp handshake.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                clear,
    alu_op_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [WIDTH-1:0]    y_q, b_q, hi_q, lo_q;
    logic [WIDTH-1:0]    rsp_hi_q, rsp_lo_q;
    logic                err_q;
    logic                accept, req_err;
    md_mode_t            mode;
    logic [WIDTH-1:0]    step_a, step_b, hi_next, lo_next;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign req_err = !is_exec_op(bus.req_op) && (bus.req_op != ALU_MUL) &&
                     !((bus.req_op == ALU_DIV) && (bus.req_b != '0));
    assign mode    = (state_q == ST_DIV) ? MD_DIV : MD_MUL;

    // MUL keeps M in Y and mq in lo; DIV keeps Q in lo and D in B.
    alu_seq_md_step #(.WIDTH(WIDTH)) u_md_step (
        .mode       (mode),
        .hi         (hi_q),
        .lo         (lo_q),
        .opnd       ((mode == MD_DIV) ? b_q : y_q),
        .alu_result (bus.alu_result),
        .step_a     (step_a),
        .step_b     (step_b),
        .hi_next    (hi_next),
        .lo_next    (lo_next)
    );

    always_ff @(posedge clk) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bus.alu_op = '0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (is_exec_op(bus.req_op))  state_d = ST_EXEC;
                    else if (!req_err)           state_d = (bus.req_op == ALU_MUL) ? ST_MUL : ST_DIV;
                    else                         state_d = ST_DONE;
                end
            end
            ST_EXEC: begin
                bus.alu_op = op_q;
                bus.alu_a  = y_q;
                bus.alu_b  = b_q;
                state_d    = ST_DONE;
            end
            ST_MUL, ST_DIV: begin
                bus.alu_op = (state_q == ST_MUL) ? ALU_ADD : ALU_SUB;
                bus.alu_a  = step_a;
                bus.alu_b  = step_b;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q    <= '0;
            op_q     <= '0;
            y_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            rsp_hi_q <= '0;
            rsp_lo_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.req_op;
                        y_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= (bus.req_op == ALU_DIV) ? bus.req_a : bus.req_b;
                        err_q <= req_err;
                        if (req_err) begin
                            rsp_hi_q <= '0;
                            rsp_lo_q <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_lo_q <= bus.alu_result;
                    rsp_hi_q <= '0;
                end
                ST_MUL, ST_DIV: begin
                    hi_q  <= hi_next;
                    lo_q  <= lo_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rsp_hi_q <= hi_next;
                        rsp_lo_q <= lo_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 8-bit ALU on the
// alu_* ports; directed vectors carry hand-computed responses and latencies.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       err;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(8)) bus ();

    alu_op_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            ALU_XOR: return a ^ b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_NOT: return ~a;
            ALU_SHL: return {a[6:0], 1'b0};
            ALU_SHR: return {1'b0, a[7:1]};
            ALU_ASR: return {a[7], a[7:1]};
            ALU_ROL: return {a[6:0], a[7]};
            ALU_ROR: return {a[0], a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clear && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hi"},  bus.rsp_hi,  e.hi);
                    chk({e.name, "_lo"},  bus.rsp_lo,  e.lo);
                    chk({e.name, "_err"}, bus.rsp_err, e.err);
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] hi, input logic [7:0] lo, input logic err,
                          input logic [3:0] first_alu, input int lat_req);
        int   lat;
        int   n;
        exp_t e;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        chk({name, "_req_ready"}, bus.req_ready, 1);
        @(posedge clk);
        e.hi = hi; e.lo = lo; e.err = err; e.name = name;
        sb.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        chk({name, "_alu_op"}, bus.alu_op, first_alu);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, lat_req);
        if (err) chk({name, "_alu_idle"}, bus.alu_op, 0);
        n = 0;
        while (bus.rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_rsp_drop"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        clear         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_rsp",       {bus.rsp_hi, bus.rsp_lo, 7'd0, bus.rsp_err}, 0);
        chk("rst_alu",       {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        clear = 1'b0;

        run_op("add",     4'd3,  8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, ALU_ADD, 2);
        run_op("mul_ff",  4'd6,  8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, ALU_ADD, 9);
        run_op("mul_13",  4'd6,  8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, ALU_ADD, 9);
        run_op("div_200", 4'd7,  8'd200, 8'd7, 8'd4,  8'd28, 1'b0, ALU_SUB, 9);
        run_op("div_z",   4'd7,  8'd5,  8'd0,  8'h00, 8'h00, 1'b1, 4'd0,    1);
        run_op("ill_14",  4'd14, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 4'd0,    1);
        run_op("and",     4'd1,  8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, ALU_AND, 2);
        run_op("xor",     4'd2,  8'hA5, 8'hFF, 8'h00, 8'h5A, 1'b0, ALU_XOR, 2);
        run_op("ror",     4'd12, 8'h01, 8'h55, 8'h00, 8'h80, 1'b0, ALU_ROR, 2);
        run_op("sub_wrap",4'd4,  8'h00, 8'h01, 8'h00, 8'hFF, 1'b0, ALU_SUB, 2);
        run_op("ill_13",  4'd13, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'd0,    1);

        // Backpressure: hold rsp_ready low with a competing request pending.
        bus.rsp_ready = 1'b0;
        bus.req_op    = ALU_OR;
        bus.req_a     = 8'h0F;
        bus.req_b     = 8'hF0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        e.hi = 8'h00; e.lo = 8'hFF; e.err = 1'b0; e.name = "bp_or";
        sb.push_back(e);
        #1;
        bus.req_op = ALU_XOR;
        bus.req_a  = 8'h11;
        bus.req_b  = 8'h22;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_valid",     bus.rsp_valid, 1);
            chk("bp_lo",        bus.rsp_lo,    8'hFF);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {bus.rsp_valid, bus.busy}, 0);

        // Abort a multiply in its fourth step.
        bus.req_op    = ALU_MUL;
        bus.req_a     = 8'hFF;
        bus.req_b     = 8'hFF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_rsp_valid", bus.rsp_valid, 0);
        chk("clr_req_ready", bus.req_ready, 1);
        chk("clr_alu_op",    bus.alu_op,    0);

        run_op("div_255", 4'd7, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, ALU_SUB, 9);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
